// File: rtl/fht_twiddle_gen.sv
// Quarter-wave sine ROM twiddle generator: direct or per-stage sequence requests,
// 3-stage registered pipeline producing (sin, cos) and the 90-degree rotated pair.
module fht_twiddle_gen #(
  parameter int    W_BIT    = 12,
  parameter int    A_BIT    = 10,
  parameter int    S_BIT    = 4,
  parameter string MIF_QSIN = "./matlab/qsin.mif"
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iADDR_VALID,
  input  logic [A_BIT-1:0] iADDR,
  input  logic             iSTART,
  input  logic [S_BIT-1:0] iSTAGE,
  input  logic             iHOLD,
  output logic             oBUSY,
  output logic             oVALID,
  output logic             oDONE,
  output logic [W_BIT-1:0] oSIN_0,
  output logic [W_BIT-1:0] oCOS_0,
  output logic [W_BIT-1:0] oSIN_1,
  output logic [W_BIT-1:0] oCOS_1
);
  localparam int Q   = 1 << (A_BIT-2);
  localparam int FB  = 60;
  localparam int AMP = (1 << (W_BIT-1)) - 1;
  localparam logic [S_BIT-1:0] SMAX = S_BIT'(A_BIT-1);
  localparam logic [A_BIT-2:0] QA   = (A_BIT-1)'(Q);

  // Table contents are computed at elaboration in 60-bit fixed point so the
  // ROM matches round(AMP*sin(pi*i/(2Q))) without needing the MIF at build time.
  function automatic logic signed [127:0] atan_inv(input int n);
    logic signed [127:0] term, sum, nn;
    term = (128'sd1 <<< FB) / 128'(n);
    nn   = 128'(n*n);
    sum  = '0;
    for (int k = 0; k < 40; k++) begin
      if ((k % 2) == 1) sum = sum - term / 128'(2*k+1);
      else              sum = sum + term / 128'(2*k+1);
      term = term / nn;
    end
    return sum;
  endfunction

  function automatic logic signed [127:0] calc_pi();
    return 128'(16) * atan_inv(5) - 128'(4) * atan_inv(239);
  endfunction

  localparam logic signed [127:0] PI_FX = calc_pi();

  function automatic logic [W_BIT-2:0] qsin(input int i);
    logic signed [127:0] x, term, s, v;
    x    = PI_FX * 128'(i) / 128'(2*Q);
    term = x;
    s    = '0;
    for (int k = 0; k < 14; k++) begin
      s    = s + term;
      term = -((((term * x) >>> FB) * x) >>> FB) / 128'((2*k+2)*(2*k+3));
    end
    v = (s * 128'(AMP) + (128'sd1 <<< (FB-1))) >>> FB;
    return v[W_BIT-2:0];
  endfunction

  logic [W_BIT-2:0] rom [0:Q];
  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    localparam logic [W_BIT-2:0] TV = qsin(gi);
    assign rom[gi] = TV;
  end

  typedef enum logic {IDLE, SEQ} state_t;
  state_t st, st_nx;

  logic [S_BIT-1:0] s_r, sh, stage_c;
  logic [A_BIT-2:0] j_r, mask;
  logic [A_BIT-1:0] seq_k, iss_k;
  logic             seq_last, iss, iss_last;

  assign stage_c  = (iSTAGE > SMAX) ? SMAX : iSTAGE;
  assign sh       = SMAX - s_r;
  assign mask     = {(A_BIT-1){1'b1}} >> sh;
  assign seq_k    = {1'b0, j_r} << sh;
  assign seq_last = (j_r == mask);

  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) st <= IDLE;
    else         st <= st_nx;

  always_comb begin
    st_nx = st;
    if (!iHOLD)
      case (st)
        IDLE:    if (iSTART) st_nx = SEQ;
        SEQ:     if (seq_last) st_nx = IDLE;
        default: st_nx = IDLE;
      endcase
  end

  // iSTART wins over iADDR_VALID; requests are dropped while sequencing.
  always_comb begin
    iss      = 1'b0;
    iss_k    = iADDR;
    iss_last = 1'b0;
    if (!iHOLD)
      case (st)
        IDLE: iss = iADDR_VALID & ~iSTART;
        SEQ: begin
          iss      = 1'b1;
          iss_k    = seq_k;
          iss_last = seq_last;
        end
        default: iss = 1'b0;
      endcase
  end

  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      s_r <= '0;
      j_r <= '0;
    end else if (!iHOLD) begin
      if (st == IDLE && iSTART) begin
        s_r <= stage_c;
        j_r <= '0;
      end else if (st == SEQ) j_r <= j_r + 1'b1;
    end

  logic [3:1]       vld_pipe, done_pipe;
  logic [1:0]       q1, q2;
  logic [A_BIT-2:0] a1, b1;
  logic [W_BIT-2:0] ta, tb;
  logic signed [W_BIT-1:0] pa, pb, sel_s, sel_c;

  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      vld_pipe  <= '0;
      done_pipe <= '0;
    end else if (!iHOLD) begin
      vld_pipe  <= {vld_pipe[2:1], iss};
      done_pipe <= {done_pipe[2:1], iss_last};
    end

  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      q1 <= '0;
      a1 <= '0;
      b1 <= '0;
    end else if (!iHOLD && iss) begin
      q1 <= iss_k[A_BIT-1:A_BIT-2];
      a1 <= {1'b0, iss_k[A_BIT-3:0]};
      b1 <= QA - {1'b0, iss_k[A_BIT-3:0]};
    end

  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      ta <= '0;
      tb <= '0;
      q2 <= '0;
    end else if (!iHOLD && vld_pipe[1]) begin
      ta <= rom[a1];
      tb <= rom[b1];
      q2 <= q1;
    end

  assign pa = {1'b0, ta};
  assign pb = {1'b0, tb};

  always_comb begin
    sel_s = pa;
    sel_c = pb;
    case (q2)
      2'd0: begin sel_s =  pa; sel_c =  pb; end
      2'd1: begin sel_s =  pb; sel_c = -pa; end
      2'd2: begin sel_s = -pa; sel_c = -pb; end
      default: begin sel_s = -pb; sel_c =  pa; end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      oSIN_0 <= '0;
      oCOS_0 <= '0;
      oSIN_1 <= '0;
      oCOS_1 <= '0;
    end else if (!iHOLD && vld_pipe[2]) begin
      oSIN_0 <= sel_s;
      oCOS_0 <= sel_c;
      oSIN_1 <= sel_c;
      oCOS_1 <= -sel_s;
    end

  assign oVALID = vld_pipe[3];
  assign oDONE  = done_pipe[3];
  assign oBUSY  = (st == SEQ) | (|vld_pipe);
endmodule

// File: tb/tb_fht_twiddle_gen.sv
// Directed bench for fht_twiddle_gen: table vectors, sequences, hold, reset abort, full sweep.
module tb_fht_twiddle_gen;
  localparam int W = 12;
  localparam int A = 10;
  localparam int S = 4;
  localparam real PI_R = 3.14159265358979323846;

  logic         iCLK = 1'b0, iRESET = 1'b0, iADDR_VALID = 1'b0, iSTART = 1'b0, iHOLD = 1'b0;
  logic [A-1:0] iADDR = '0;
  logic [S-1:0] iSTAGE = '0;
  logic         oBUSY, oVALID, oDONE;
  logic [W-1:0] oSIN_0, oCOS_0, oSIN_1, oCOS_1;

  fht_twiddle_gen #(.W_BIT(W), .A_BIT(A), .S_BIT(S), .MIF_QSIN("./matlab/qsin.mif")) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iADDR_VALID(iADDR_VALID), .iADDR(iADDR),
    .iSTART(iSTART), .iSTAGE(iSTAGE), .iHOLD(iHOLD), .oBUSY(oBUSY), .oVALID(oVALID),
    .oDONE(oDONE), .oSIN_0(oSIN_0), .oCOS_0(oCOS_0), .oSIN_1(oSIN_1), .oCOS_1(oCOS_1)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int k; int es; int ec; } vec_t;
  vec_t vt[11];
  int   kq[$];

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sv(input logic [W-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic int rnd(input real y);
    if (y >= 0.0) return int'($floor(y + 0.5));
    return -int'($floor(-y + 0.5));
  endfunction

  function automatic int rsin(input int k);
    return rnd(2047.0 * $sin(2.0 * PI_R * real'(k) / 1024.0));
  endfunction

  function automatic int rcos(input int k);
    return rnd(2047.0 * $cos(2.0 * PI_R * real'(k) / 1024.0));
  endfunction

  task automatic chk_word(input string nm, input int es, input int ec);
    chk({nm, "_vld"},  int'(oVALID), 1);
    chk({nm, "_sin0"}, sv(oSIN_0), es);
    chk({nm, "_cos0"}, sv(oCOS_0), ec);
    chk({nm, "_sin1"}, sv(oSIN_1), ec);
    chk({nm, "_cos1"}, sv(oCOS_1), -es);
  endtask

  // Back-to-back direct stream from kq, compared against the rounded-sine model.
  task automatic run_stream(input string nm);
    int n, s, c, e;
    n = kq.size();
    for (int i = 0; i < n + 2; i++) begin
      iADDR_VALID = (i < n);
      if (i < n) iADDR = A'(kq[i]);
      tick();
      if (i >= 2) begin
        chk_word(nm, rsin(kq[i-2]), rcos(kq[i-2]));
        s = sv(oSIN_0);
        c = sv(oCOS_0);
        e = s*s + c*c - 2047*2047;
        if (e < 0) e = -e;
        chk({nm, "_norm"}, int'(e <= 41902), 1);
      end
    end
    iADDR_VALID = 1'b0;
  endtask

  task automatic run_seq(input int stg);
    int se, n, stride, got;
    se     = (stg > 9) ? 9 : stg;
    n      = 1 << se;
    stride = 1 << (9 - se);
    got    = 0;
    iSTART = 1'b1;
    iSTAGE = S'(stg);
    tick();
    iSTART = 1'b0;
    chk("seq_busy", int'(oBUSY), 1);
    for (int c = 0; c < n + 20 && got < n; c++) begin
      tick();
      if (oVALID) begin
        chk("seq_sin",  sv(oSIN_0), rsin(got * stride));
        chk("seq_cos",  sv(oCOS_0), rcos(got * stride));
        chk("seq_done", int'(oDONE), int'(got == n - 1));
        got++;
      end else if (got > 0) chk("seq_gap", int'(oVALID), 1);
    end
    chk("seq_count", got, n);
    tick();
    chk("seq_busy_end", int'(oBUSY), 0);
    chk("seq_vld_end",  int'(oVALID), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int got;
    vt[0]  = '{0,    0,     2047};
    vt[1]  = '{256,  2047,  0};
    vt[2]  = '{512,  0,     -2047};
    vt[3]  = '{768,  -2047, 0};
    vt[4]  = '{128,  1447,  1447};
    vt[5]  = '{896,  -1447, 1447};
    vt[6]  = '{384,  1447,  -1447};
    vt[7]  = '{64,   783,   1891};
    vt[8]  = '{1,    13,    2047};
    vt[9]  = '{1023, -13,   2047};
    vt[10] = '{640,  -1447, -1447};

    tick(); tick();
    chk("rst_vld",  int'(oVALID), 0);
    chk("rst_done", int'(oDONE), 0);
    chk("rst_busy", int'(oBUSY), 0);
    chk("rst_sin0", sv(oSIN_0), 0);
    chk("rst_cos1", sv(oCOS_1), 0);
    iRESET = 1'b1;
    tick();

    // Single request latency
    iADDR_VALID = 1'b1;
    iADDR = 10'd256;
    tick();
    iADDR_VALID = 1'b0;
    chk("lat_c1", int'(oVALID), 0);
    tick();
    chk("lat_c2", int'(oVALID), 0);
    tick();
    chk_word("lat_c3", 2047, 0);
    tick();
    chk("lat_pulse", int'(oVALID), 0);

    for (int i = 0; i < 13; i++) begin
      iADDR_VALID = (i < 11);
      if (i < 11) iADDR = A'(vt[i].k);
      tick();
      if (i >= 2) chk_word($sformatf("vec_k%0d", vt[i-2].k), vt[i-2].es, vt[i-2].ec);
    end
    iADDR_VALID = 1'b0;
    tick();
    chk("vec_idle_vld",  int'(oVALID), 0);
    chk("vec_idle_busy", int'(oBUSY), 0);

    run_seq(2);
    chk("s2_last_sin", sv(oSIN_0), 1447);
    chk("s2_last_cos", sv(oCOS_0), -1447);
    run_seq(0);
    run_seq(12);

    // Stage 9 with a 5-cycle hold after j=10 and an ignored mid-sequence start
    got = 0;
    iSTART = 1'b1;
    iSTAGE = 4'd9;
    tick();
    iSTART = 1'b0;
    for (int c = 0; c < 700 && got < 512; c++) begin
      iSTART      = (got == 100);
      iADDR_VALID = (got == 100);
      iADDR       = 10'd5;
      tick();
      if (oVALID) begin
        chk("s9_sin",  sv(oSIN_0), rsin(got));
        chk("s9_cos",  sv(oCOS_0), rcos(got));
        chk("s9_done", int'(oDONE), int'(got == 511));
        if (got == 10) begin
          iHOLD = 1'b1;
          repeat (5) begin
            tick();
            chk("hold_vld",  int'(oVALID), 1);
            chk("hold_sin",  sv(oSIN_0), rsin(10));
            chk("hold_busy", int'(oBUSY), 1);
          end
          iHOLD = 1'b0;
        end
        got++;
      end else if (got > 0) chk("s9_gap", int'(oVALID), 1);
    end
    iSTART = 1'b0;
    iADDR_VALID = 1'b0;
    chk("s9_count", got, 512);
    tick();
    chk("s9_busy_end", int'(oBUSY), 0);

    // Asynchronous reset during a sequence
    iSTART = 1'b1;
    iSTAGE = 4'd9;
    tick();
    iSTART = 1'b0;
    repeat (4) tick();
    chk("rst_pre_vld", int'(oVALID), 1);
    #2 iRESET = 1'b0;
    #1;
    chk("arst_vld",  int'(oVALID), 0);
    chk("arst_done", int'(oDONE), 0);
    chk("arst_busy", int'(oBUSY), 0);
    chk("arst_sin0", sv(oSIN_0), 0);
    @(posedge iCLK);
    #1 iRESET = 1'b1;
    tick();
    chk("arst_idle_busy", int'(oBUSY), 0);
    iADDR_VALID = 1'b1;
    iADDR = 10'd64;
    tick();
    iADDR_VALID = 1'b0;
    tick(); tick();
    chk_word("arst_k64", 783, 1891);
    tick();

    for (int k = 0; k < 1024; k++) kq.push_back(k);
    run_stream("sweep");
    kq.delete();
    for (int i = 0; i < 100; i++) kq.push_back(int'($urandom_range(0, 1023)));
    run_stream("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
